// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code receive path (gray_decoder).
package gray_pkg;

  localparam int unsigned MAX_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  // Works for any width up to MAX_WIDTH: zero-extended Gray bits decode to
  // zero-extended binary bits, so callers pad and truncate.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Purely combinational WIDTH-bit Gray-to-binary converter.
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary
);

  assign binary = WIDTH'(gray2bin(MAX_WIDTH'(gray)));

endmodule

// File: rtl/gray_decoder.sv
// Gray-stream decoder/monitor: converts with 1-cycle latency and checks sequence legality.
// Optional macro GRAY_DECODER_RESYNC_EN lets the ERR state recover on two successive codes.
module gray_decoder
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Valid,
  input  logic [WIDTH-1:0] Gray,
  input  logic             ClrErr,
  output logic [WIDTH-1:0] Binary,
  output logic             BinValid,
  output logic             Wrap,
  output logic             Locked,
  output logic             Error
);

  localparam logic [WIDTH-1:0] MAX_CODE = '1;

  state_t           state, state_d;
  logic [WIDTH-1:0] prev, prev_d;
  logic [WIDTH-1:0] binary_d;
  logic             binvalid_d, wrap_d;
  logic [WIDTH-1:0] bin_in;
  logic             is_succ, is_hold;
`ifdef GRAY_DECODER_RESYNC_EN
  // Set once ERR has taken a reference sample and can test the next for succession.
  logic             armed, armed_d;
`endif

  gray_to_bin #(.WIDTH(WIDTH)) u_conv (
    .gray   (Gray),
    .binary (bin_in)
  );

  assign is_succ = (bin_in == prev + WIDTH'(1));
  assign is_hold = (bin_in == prev);
  assign Locked  = (state == S_TRACK);
  assign Error   = (state == S_ERR);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d    = state;
    prev_d     = prev;
    binary_d   = Binary;
    binvalid_d = 1'b0;
    wrap_d     = 1'b0;
`ifdef GRAY_DECODER_RESYNC_EN
    armed_d    = armed;
`endif
    if (ClrErr) begin
      state_d = S_IDLE;
      prev_d  = '0;
`ifdef GRAY_DECODER_RESYNC_EN
      armed_d = 1'b0;
`endif
    end else if (Valid) begin
      case (state)
        S_IDLE: begin
          prev_d     = bin_in;
          binary_d   = bin_in;
          binvalid_d = 1'b1;
          state_d    = S_TRACK;
        end
        S_TRACK: begin
          if (is_succ) begin
            prev_d     = bin_in;
            binary_d   = bin_in;
            binvalid_d = 1'b1;
            wrap_d     = (prev == MAX_CODE);
          end else if (is_hold) begin
            binvalid_d = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
        S_ERR: begin
`ifdef GRAY_DECODER_RESYNC_EN
          prev_d = bin_in;
          if (armed && is_succ) begin
            state_d    = S_TRACK;
            binary_d   = bin_in;
            binvalid_d = 1'b1;
            wrap_d     = (prev == MAX_CODE);
            armed_d    = 1'b0;
          end else begin
            armed_d = 1'b1;
          end
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      prev     <= '0;
      Binary   <= '0;
      BinValid <= 1'b0;
      Wrap     <= 1'b0;
`ifdef GRAY_DECODER_RESYNC_EN
      armed    <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      prev     <= prev_d;
      Binary   <= binary_d;
      BinValid <= binvalid_d;
      Wrap     <= wrap_d;
`ifdef GRAY_DECODER_RESYNC_EN
      armed    <= armed_d;
`endif
    end
  end

endmodule

// File: tb/tb_gray_decoder.sv
// Scoreboard bench for gray_decoder (WIDTH=3): directed Gray vectors, monitor pops on BinValid.
module tb_gray_decoder;

  localparam int W = 3;

  typedef struct packed {
    logic [W-1:0] bin;
    logic         wrap;
  } exp_t;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         Valid;
  logic [W-1:0] Gray;
  logic         ClrErr;
  logic [W-1:0] Binary;
  logic         BinValid, Wrap, Locked, Error;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 Clk = ~Clk;

  gray_decoder #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Valid    (Valid),
    .Gray     (Gray),
    .ClrErr   (ClrErr),
    .Binary   (Binary),
    .BinValid (BinValid),
    .Wrap     (Wrap),
    .Locked   (Locked),
    .Error    (Error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic send(input logic v, input logic [W-1:0] g, input logic c,
                      input logic exp_bv, input logic [W-1:0] eb, input logic ew);
    @(negedge Clk);
    Valid  = v;
    Gray   = g;
    ClrErr = c;
    if (exp_bv) exp_q.push_back('{bin: eb, wrap: ew});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      Valid  = 1'b0;
      ClrErr = 1'b0;
    end
  endtask

  task automatic check_levels(input string tag, input logic [W-1:0] b,
                              input logic l, input logic e);
    check({tag, "_binary"}, 32'(Binary), 32'(b));
    check({tag, "_locked"}, 32'(Locked), 32'(l));
    check({tag, "_error"},  32'(Error),  32'(e));
  endtask

  // Monitor: every BinValid consumes one expectation; Wrap must never appear alone.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset_n === 1'b1) begin
      if (BinValid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_binvalid", 32'(BinValid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("mon_binary", 32'(Binary), 32'(e.bin));
          check("mon_wrap",   32'(Wrap),   32'(e.wrap));
        end
      end else begin
        check("wrap_without_binvalid", 32'(Wrap), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] t1_g [9];
  logic [W-1:0] t1_b [9];

  initial begin
    t1_g = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    t1_b = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

    Reset_n = 1'b0;
    Valid   = 1'b0;
    ClrErr  = 1'b0;
    Gray    = '0;
    #15;
    check("rst_binary",   32'(Binary),   32'd0);
    check("rst_binvalid", 32'(BinValid), 32'd0);
    check("rst_wrap",     32'(Wrap),     32'd0);
    check("rst_locked",   32'(Locked),   32'd0);
    check("rst_error",    32'(Error),    32'd0);
    #5 Reset_n = 1'b1;

    // 1: full count with wrap 7 -> 0
    for (int i = 0; i < 9; i++) begin
      send(1'b1, t1_g[i], 1'b0, 1'b1, t1_b[i], (i == 8));
      if (i == 2) check_levels("t1_mid", 3'd1, 1'b1, 1'b0);
    end
    idle(1);
    check_levels("t1_end", 3'd0, 1'b1, 1'b0);

    // 2: succ, hold, succ
    send(1'b1, 3'b001, 1'b0, 1'b1, 3'd1, 1'b0);
    send(1'b1, 3'b001, 1'b0, 1'b1, 3'd1, 1'b0);
    send(1'b1, 3'b011, 1'b0, 1'b1, 3'd2, 1'b0);
    idle(1);
    check_levels("t2", 3'd2, 1'b1, 1'b0);

    // 3: illegal jump 1 -> 3, then ClrErr beats a simultaneous Valid
    send(1'b0, 3'b000, 1'b1, 1'b0, 3'd0, 1'b0);
    send(1'b1, 3'b001, 1'b0, 1'b1, 3'd1, 1'b0);
    idle(1);
    check_levels("t3_capture", 3'd1, 1'b1, 1'b0);
    send(1'b1, 3'b010, 1'b0, 1'b0, 3'd0, 1'b0);
    idle(1);
    check_levels("t3_err", 3'd1, 1'b0, 1'b1);
    send(1'b1, 3'b011, 1'b1, 1'b0, 3'd0, 1'b0);
    idle(1);
    check_levels("t3_clr", 3'd1, 1'b0, 1'b0);

    // 5: resync attempt from ERR with 111, 101
    send(1'b1, 3'b001, 1'b0, 1'b1, 3'd1, 1'b0);
    send(1'b1, 3'b010, 1'b0, 1'b0, 3'd0, 1'b0);
    idle(1);
    check_levels("t5_err", 3'd1, 1'b0, 1'b1);
`ifdef GRAY_DECODER_RESYNC_EN
    send(1'b1, 3'b111, 1'b0, 1'b0, 3'd0, 1'b0);
    send(1'b1, 3'b101, 1'b0, 1'b1, 3'd6, 1'b0);
    idle(1);
    check_levels("t5_resync", 3'd6, 1'b1, 1'b0);
`else
    send(1'b1, 3'b111, 1'b0, 1'b0, 3'd0, 1'b0);
    send(1'b1, 3'b101, 1'b0, 1'b0, 3'd0, 1'b0);
    idle(1);
    check_levels("t5_stuck", 3'd1, 1'b0, 1'b1);
`endif

    // 6: ten idle cycles while tracking at 6
    send(1'b0, 3'b000, 1'b1, 1'b0, 3'd0, 1'b0);
    send(1'b1, 3'b101, 1'b0, 1'b1, 3'd6, 1'b0);
    idle(1);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check_levels("t6_hold", 3'd6, 1'b1, 1'b0);
    end

    // 4: asynchronous reset between edges, right after Binary became 7
    send(1'b1, 3'b100, 1'b0, 1'b0, 3'd0, 1'b0);
    @(posedge Clk);
    #1 check("t4_pre_binvalid", 32'(BinValid), 32'd1);
    #2;
    Reset_n = 1'b0;
    Valid   = 1'b0;
    #1;
    check("t4_rst_binary",   32'(Binary),   32'd0);
    check("t4_rst_binvalid", 32'(BinValid), 32'd0);
    check("t4_rst_wrap",     32'(Wrap),     32'd0);
    check("t4_rst_locked",   32'(Locked),   32'd0);
    check("t4_rst_error",    32'(Error),    32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    send(1'b1, 3'b110, 1'b0, 1'b1, 3'd4, 1'b0);
    idle(1);
    check_levels("t4_after", 3'd4, 1'b1, 1'b0);

    idle(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
